count_bcd_converter: RTL and testbench



---
 rtl/count_pkg.sv | 27 ++
 rtl/count_bcd_converter_if.sv | 38 +++
 rtl/bcd_digit_adj.sv | 9 +
 rtl/count_bcd_converter.sv | 109 ++++++++++
 tb/tb_count_bcd_converter.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/count_pkg.sv
// Shared definitions for the count BCD conversion slice: default widths,
// converter FSM states and the significant-digit helper.
package count_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int DIGITS_DEF = 10;
    localparam int MAX_DIGITS = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Callers zero-extend their packed BCD to MAX_DIGITS; a zero value still reports one digit.
    function automatic int clz_digits(input logic [4*MAX_DIGITS-1:0] bcd, input int ndig);
        int n;
        n = 1;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if ((i < ndig) && (bcd[4*i +: 4] != 4'd0)) begin
                n = i + 1;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/count_bcd_converter_if.sv
// Handshake bundle between the counter result, the BCD converter and the display stage.
interface count_bcd_converter_if
    import count_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DIGITS = DIGITS_DEF,
    parameter int NDIG_W = 4
);

    logic                in_valid;
    logic                in_ready;
    logic [DATA_W-1:0]   in_data;
    logic                out_valid;
    logic                out_ready;
    logic [4*DIGITS-1:0] out_bcd;
    logic [NDIG_W-1:0]   out_ndigits;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_bcd,
        input  out_ndigits
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_bcd,
        output out_ndigits
    );

endinterface

// File: rtl/bcd_digit_adj.sv
// Double-dabble correction for one BCD digit: add 3 when the digit is 5 or more.
module bcd_digit_adj (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = (din >= 4'd5) ? (din + 4'd3) : din;

endmodule

// File: rtl/count_bcd_converter.sv
// Iterative binary-to-packed-BCD converter with significant-digit count,
// valid/ready on both sides and one conversion in flight.
module count_bcd_converter
    import count_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DIGITS = DIGITS_DEF,
    parameter int NDIG_W = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    count_bcd_converter_if.slave bus
);

    localparam int BCD_W  = 4 * DIGITS;
    localparam int ITER_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    state_t state, state_next;

    logic [DATA_W-1:0]      bin_q;
    logic [DATA_W-1:0]      bin_next;
    logic [BCD_W-1:0]       bcd_q;
    logic [BCD_W-1:0]       bcd_adj;
    logic [BCD_W-1:0]       bcd_next;
    logic [ITER_W-1:0]      iter_q;
    logic [BCD_W-1:0]       out_bcd_q;
    logic [NDIG_W-1:0]      out_ndig_q;
    logic [NDIG_W-1:0]      ndig_next;
    logic [4*MAX_DIGITS-1:0] bcd_wide;
    logic                   last_iter;
    logic                   in_fire;
    logic                   out_fire;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (bcd_q[4*g +: 4]),
            .dout (bcd_adj[4*g +: 4])
        );
    end

    assign {bcd_next, bin_next} = {bcd_adj, bin_q} << 1;
    assign last_iter            = (iter_q == ITER_W'(DATA_W - 1));

    assign bus.in_ready    = (state == IDLE) && !reset;
    assign bus.out_valid   = (state == DONE);
    assign bus.out_bcd     = out_bcd_q;
    assign bus.out_ndigits = out_ndig_q;

    assign in_fire  = bus.in_valid && bus.in_ready;
    assign out_fire = bus.out_valid && bus.out_ready;

    always_comb begin
        bcd_wide                = '0;
        bcd_wide[BCD_W-1:0]     = bcd_next;
        ndig_next               = NDIG_W'(clz_digits(bcd_wide, DIGITS));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_fire)   state_next = SHIFT;
            SHIFT:   if (last_iter) state_next = DONE;
            DONE:    if (out_fire)  state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // Result registers load only on the final iteration, so they stay frozen while DONE waits.
    always_ff @(posedge clk) begin
        if (reset) begin
            bin_q      <= '0;
            bcd_q      <= '0;
            iter_q     <= '0;
            out_bcd_q  <= '0;
            out_ndig_q <= NDIG_W'(1);
        end else begin
            case (state)
                IDLE: begin
                    if (in_fire) begin
                        bin_q  <= bus.in_data;
                        bcd_q  <= '0;
                        iter_q <= '0;
                    end
                end
                SHIFT: begin
                    bin_q <= bin_next;
                    bcd_q <= bcd_next;
                    if (last_iter) begin
                        out_bcd_q  <= bcd_next;
                        out_ndig_q <= ndig_next;
                    end else begin
                        iter_q <= iter_q + ITER_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_count_bcd_converter.sv
// Scoreboard bench for count_bcd_converter: a decimal reference model predicts each
// capture, and a negedge monitor checks results, latency and stall stability.
module tb_count_bcd_converter;

    typedef struct {
        logic [39:0] bcd;
        logic [3:0]  nd;
        int          cap;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc;
    int   checks;
    int   passes;
    int   ready_mode;
    logic prev_valid;
    logic expect_drop;
    exp_t expq[$];

    count_bcd_converter_if #(.DATA_W(32), .DIGITS(10), .NDIG_W(4)) bus ();

    count_bcd_converter #(.DATA_W(32), .DIGITS(10), .NDIG_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    initial begin
        #600000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic exp_t model(input logic [31:0] v, input int cap);
        exp_t            e;
        longint unsigned t;
        e.bcd = '0;
        t     = longint'(v);
        for (int i = 0; i < 10; i++) begin
            e.bcd[4*i +: 4] = 4'(t % 10);
            t               = t / 10;
        end
        e.nd = 4'd1;
        t    = longint'(v);
        while (t >= 10) begin
            t    = t / 10;
            e.nd = e.nd + 4'd1;
        end
        e.cap = cap;
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    endtask

    task automatic noteFailure(input string name, input string msg);
        checks++;
        $display("[TB] FAIL %s: %s", name, msg);
    endtask

    // Drives one capture and records its predicted result once the handshake edge has passed.
    task automatic applyStimulus(input logic [31:0] v);
        bit ok;
        ok = 1'b0;
        @(posedge clk);
        #2;
        bus.in_valid = 1'b1;
        bus.in_data  = v;
        for (int n = 0; n < 500; n++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            noteFailure("in_ready_timeout", "in_ready never rose");
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        expq.push_back(model(v, cyc));
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic waitValid();
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (bus.out_valid) return;
        end
        noteFailure("out_valid_timeout", "out_valid never rose");
    endtask

    task automatic waitIdle();
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if ((expq.size() == 0) && !bus.out_valid) return;
        end
        noteFailure("drain_timeout", "pending results not delivered");
    endtask

    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = 1'($urandom_range(0, 1));
                default: bus.out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: each visible result is compared with the oldest prediction until it is accepted.
    always @(negedge clk) begin
        if (reset) begin
            prev_valid  = 1'b0;
            expect_drop = 1'b0;
        end else begin
            if (expect_drop) begin
                checkOutput("out_valid_drop", 64'(bus.out_valid), 64'(0));
                expect_drop = 1'b0;
            end
            if (bus.out_valid) begin
                if (expq.size() == 0) begin
                    if (!prev_valid) noteFailure("spurious_valid", "out_valid with no capture pending");
                end else begin
                    if (!prev_valid) checkOutput("latency", 64'(cyc - expq[0].cap), 64'(32));
                    checkOutput("out_bcd", 64'(bus.out_bcd), 64'(expq[0].bcd));
                    checkOutput("out_ndigits", 64'(bus.out_ndigits), 64'(expq[0].nd));
                    checkOutput("in_ready_busy", 64'(bus.in_ready), 64'(0));
                    if (bus.out_ready) begin
                        void'(expq.pop_front());
                        expect_drop = 1'b1;
                    end
                end
            end
            prev_valid = bus.out_valid;
        end
    end

    initial begin
        int errs;
        checks       = 0;
        passes       = 0;
        cyc          = 0;
        ready_mode   = 0;
        prev_valid   = 1'b0;
        expect_drop  = 1'b0;
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;

        repeat (10) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_out_valid", 64'(bus.out_valid), 64'(0));
        checkOutput("rst_out_bcd", 64'(bus.out_bcd), 64'(0));
        checkOutput("rst_out_ndigits", 64'(bus.out_ndigits), 64'(1));
        checkOutput("rst_in_ready", 64'(bus.in_ready), 64'(0));
        @(posedge clk);
        #2;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("in_ready_after_reset", 64'(bus.in_ready), 64'(1));

        $display("[TB] zero and all-ones");
        applyStimulus(32'd0);
        waitIdle();
        applyStimulus(32'hFFFF_FFFF);
        waitIdle();

        $display("[TB] back-to-back captures");
        applyStimulus(32'd1000000);
        applyStimulus(32'd999);
        applyStimulus(32'd10);
        waitIdle();

        $display("[TB] output stall");
        ready_mode = 2;
        applyStimulus(32'd31337);
        waitValid();
        repeat (5) @(negedge clk);
        ready_mode = 0;
        waitIdle();

        $display("[TB] in_valid during SHIFT");
        applyStimulus(32'd123);
        repeat (5) @(posedge clk);
        #2;
        bus.in_valid = 1'b1;
        bus.in_data  = 32'd5;
        @(negedge clk);
        checkOutput("in_ready_shift", 64'(bus.in_ready), 64'(0));
        @(posedge clk);
        #2;
        bus.in_valid = 1'b0;
        waitIdle();

        $display("[TB] reset during SHIFT");
        applyStimulus(32'd777777);
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b1;
        expq.delete();
        @(negedge clk);
        @(negedge clk);
        checkOutput("abort_out_valid", 64'(bus.out_valid), 64'(0));
        checkOutput("abort_out_bcd", 64'(bus.out_bcd), 64'(0));
        @(posedge clk);
        #2;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("abort_in_ready", 64'(bus.in_ready), 64'(1));
        errs = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.out_valid) errs++;
        end
        checkOutput("abort_no_valid", 64'(errs), 64'(0));
        applyStimulus(32'd42);
        waitIdle();

        $display("[TB] reset during DONE");
        ready_mode = 2;
        applyStimulus(32'd4000000000);
        waitValid();
        @(posedge clk);
        #2;
        reset = 1'b1;
        expq.delete();
        @(negedge clk);
        @(negedge clk);
        checkOutput("done_abort_valid", 64'(bus.out_valid), 64'(0));
        checkOutput("done_abort_ndigits", 64'(bus.out_ndigits), 64'(1));
        @(posedge clk);
        #2;
        reset      = 1'b0;
        ready_mode = 0;

        $display("[TB] randomized conversions");
        ready_mode = 1;
        for (int k = 0; k < 16; k++) begin
            logic [31:0] v;
            v = 32'($urandom) >> $urandom_range(0, 31);
            applyStimulus(v);
        end
        applyStimulus(32'd9);
        applyStimulus(32'd100);
        applyStimulus(32'd999999999);
        waitIdle();
        ready_mode = 0;
        repeat (3) @(posedge clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
